// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: controller states, twiddle sizing
// and a constant-evaluable clog2 helper.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_state_t;

    localparam int EXPAND   = 6;
    localparam int TW_WIDTH = EXPAND + 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries write tags and
// the read strobe across the memory/butterfly latency.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: read/twiddle address generation,
// butterfly enable, aligned write-back tags and valid cross-check.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one butterfly read per cycle, k = 0..N/2-1
//   DRAIN | wait PIPE cycles for the stage's write-back to land
//   DONE  | one-cycle completion pulse
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2  = 3,
    parameter int MEM_LAT = 1,
    parameter int BF_LAT  = 1,
    localparam int ST_W   = clog2(N_LOG2) + 1,
    localparam int TW_W   = (N_LOG2 > 1) ? N_LOG2 - 1 : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ST_W-1:0]   stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_addr,
    output logic              bf_en,
    input  logic              bf_valid,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    localparam int HALF  = (1 << N_LOG2) / 2;
    localparam int PIPE  = MEM_LAT + BF_LAT;
    localparam int CNT_W = clog2(PIPE) + 1;

    fft_state_t        state, state_next;
    logic [N_LOG2-1:0] k_q, k_next;
    logic [ST_W-1:0]   stage_next;
    logic [CNT_W-1:0]  cnt_q, cnt_next;
    logic [N_LOG2-1:0] a_next, b_next;
    logic [TW_W-1:0]   tw_next;

    function automatic logic [31:0] op_a(input int s, input int k);
        int half, pos, grp;
        half = 1 << s;
        pos  = k & (half - 1);
        grp  = k >> s;
        return 32'((grp << (s + 1)) | pos);
    endfunction

    function automatic logic [31:0] op_tw(input int s, input int k);
        int pos;
        pos = k & ((1 << s) - 1);
        return 32'(pos << (N_LOG2 - 1 - s));
    endfunction

    always_comb begin
        state_next = state;
        k_next     = k_q;
        stage_next = stage;
        cnt_next   = cnt_q;
        case (state)
            IDLE: if (start) begin
                state_next = RUN;
                k_next     = '0;
                stage_next = '0;
            end
            RUN: begin
                if (k_q == N_LOG2'(HALF - 1)) begin
                    state_next = DRAIN;
                    cnt_next   = CNT_W'(PIPE - 1);
                end else begin
                    k_next = k_q + N_LOG2'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    if (stage == ST_W'(N_LOG2 - 1)) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                        stage_next = stage + ST_W'(1);
                        k_next     = '0;
                    end
                end else begin
                    cnt_next = cnt_q - CNT_W'(1);
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Addresses for the read about to be issued, zero outside RUN.
    always_comb begin
        logic [31:0] a32, tw32;
        a_next  = '0;
        b_next  = '0;
        tw_next = '0;
        a32     = op_a(int'(stage_next), int'(k_next));
        tw32    = op_tw(int'(stage_next), int'(k_next));
        if (state_next == RUN) begin
            a_next  = a32[N_LOG2-1:0];
            b_next  = a32[N_LOG2-1:0] + N_LOG2'(1 << int'(stage_next));
            tw_next = tw32[TW_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_q       <= '0;
            stage     <= '0;
            cnt_q     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            state     <= state_next;
            k_q       <= k_next;
            stage     <= stage_next;
            cnt_q     <= cnt_next;
            rd_en     <= (state_next == RUN);
            rd_addr_a <= a_next;
            rd_addr_b <= b_next;
            tw_addr   <= tw_next;
        end
    end

    fft_delay_line #(.WIDTH(1), .DEPTH(MEM_LAT)) u_bf_dl (
        .clk  (clk),
        .clr  (!rst_n),
        .din  (rd_en),
        .dout (bf_en)
    );

    fft_delay_line #(.WIDTH(1 + 2 * N_LOG2), .DEPTH(PIPE)) u_wr_dl (
        .clk  (clk),
        .clr  (!rst_n),
        .din  ({rd_en, rd_addr_a, rd_addr_b}),
        .dout ({wr_en, wr_addr_a, wr_addr_b})
    );

    always_ff @(posedge clk) begin
        if (!rst_n)                    err <= 1'b0;
        else if (state == IDLE && start) err <= 1'b0;
        else if (wr_en != bf_valid)    err <= 1'b1;
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl: 8-point sequence, write alignment, error
// flag, start filtering, mid-run reset and a 16-point deep-pipeline case.
module tb_fft_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, start6, glitch;
    int   checks = 0;
    int   errors = 0;

    logic       busy, done, err, rd_en, bf_en, bf_valid, wr_en;
    logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;
    logic       bfv_q;

    logic       busy6, done6, err6, rd_en6, bf_en6, bf_valid6, wr_en6;
    logic [2:0] stage6;
    logic [3:0] rd_addr_a6, rd_addr_b6, wr_addr_a6, wr_addr_b6;
    logic [2:0] tw_addr6;
    logic [2:0] bfv6_q;

    always #5 clk = ~clk;

    fft_ctrl #(.N_LOG2(3), .MEM_LAT(1), .BF_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .stage(stage), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .tw_addr(tw_addr), .bf_en(bf_en),
        .bf_valid(bf_valid), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
        .wr_addr_b(wr_addr_b)
    );

    fft_ctrl #(.N_LOG2(4), .MEM_LAT(2), .BF_LAT(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .busy(busy6), .done(done6),
        .err(err6), .stage(stage6), .rd_en(rd_en6), .rd_addr_a(rd_addr_a6),
        .rd_addr_b(rd_addr_b6), .tw_addr(tw_addr6), .bf_en(bf_en6),
        .bf_valid(bf_valid6), .wr_en(wr_en6), .wr_addr_a(wr_addr_a6),
        .wr_addr_b(wr_addr_b6)
    );

    // Ideal butterflies: valid is en delayed by BF_LAT, reset with the DUT.
    always @(posedge clk) begin
        bfv_q  <= rst_n ? bf_en : 1'b0;
        bfv6_q <= rst_n ? {bfv6_q[1:0], bf_en6} : 3'b000;
    end
    assign bf_valid  = bfv_q ^ glitch;
    assign bf_valid6 = bfv6_q[2];

    // Expected 8-point read sequence indexed by cycle (0 = start sampled).
    int rd_t[21] = '{0,1,1,1,1,0,0,1,1,1,1,0,0,1,1,1,1,0,0,0,0};
    int a_t [21] = '{0,0,2,4,6,0,0,0,1,4,5,0,0,0,1,2,3,0,0,0,0};
    int b_t [21] = '{0,1,3,5,7,0,0,2,3,6,7,0,0,4,5,6,7,0,0,0,0};
    int tw_t[21] = '{0,0,0,0,0,0,0,0,2,0,2,0,0,0,1,2,3,0,0,0,0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"},  32'(busy),  0);
        chk({tag, ".done"},  32'(done),  0);
        chk({tag, ".err"},   32'(err),   0);
        chk({tag, ".stage"}, 32'(stage), 0);
        chk({tag, ".rd_en"}, 32'(rd_en), 0);
        chk({tag, ".rd_a"},  32'(rd_addr_a), 0);
        chk({tag, ".rd_b"},  32'(rd_addr_b), 0);
        chk({tag, ".tw"},    32'(tw_addr), 0);
        chk({tag, ".bf_en"}, 32'(bf_en), 0);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_a"},  32'(wr_addr_a), 0);
        chk({tag, ".wr_b"},  32'(wr_addr_b), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start6 = 1'b0;
        glitch = 1'b0;
        tick();
        tick();
        chk_zero("reset");
        chk("reset.busy6", 32'(busy6), 0);
        chk("reset.wr_en6", 32'(wr_en6), 0);

        // Run 1: address sequence, write alignment, busy/done, err quiet.
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk($sformatf("r1.c%0d.rd_en", c), 32'(rd_en), 32'(rd_t[c]));
            chk($sformatf("r1.c%0d.rd_a", c), 32'(rd_addr_a), 32'(a_t[c]));
            chk($sformatf("r1.c%0d.rd_b", c), 32'(rd_addr_b), 32'(b_t[c]));
            chk($sformatf("r1.c%0d.tw", c), 32'(tw_addr), 32'(tw_t[c]));
            chk($sformatf("r1.c%0d.bf_en", c), 32'(bf_en), 32'(rd_t[c-1]));
            chk($sformatf("r1.c%0d.wr_en", c), 32'(wr_en), (c >= 2) ? 32'(rd_t[c-2]) : 0);
            chk($sformatf("r1.c%0d.wr_a", c), 32'(wr_addr_a), (c >= 2) ? 32'(a_t[c-2]) : 0);
            chk($sformatf("r1.c%0d.wr_b", c), 32'(wr_addr_b), (c >= 2) ? 32'(b_t[c-2]) : 0);
            chk($sformatf("r1.c%0d.busy", c), 32'(busy), (c >= 1 && c <= 18) ? 1 : 0);
            chk($sformatf("r1.c%0d.done", c), 32'(done), (c == 19) ? 1 : 0);
            chk($sformatf("r1.c%0d.err", c), 32'(err), 0);
            if (c <= 18)
                chk($sformatf("r1.c%0d.stage", c), 32'(stage), (c <= 6) ? 0 : (c <= 12) ? 1 : 2);
            tick();
        end

        // Run 2: a valid dropout in cycle 5 (wr_en high) must latch err.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            glitch = (c == 5);
            chk($sformatf("r2.c%0d.err", c), 32'(err), (c >= 6) ? 1 : 0);
            tick();
        end
        glitch = 1'b0;

        // Run 3: accepted start clears err; mid-run start ignored; held start
        // gives exactly one IDLE cycle before the next transform.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            if (c == 1) chk("r3.c1.err", 32'(err), 0);
            if (c <= 20) begin
                chk($sformatf("r3.c%0d.rd_a", c), 32'(rd_addr_a), 32'(a_t[c]));
                chk($sformatf("r3.c%0d.rd_b", c), 32'(rd_addr_b), 32'(b_t[c]));
                chk($sformatf("r3.c%0d.busy", c), 32'(busy), (c <= 18) ? 1 : 0);
                chk($sformatf("r3.c%0d.done", c), 32'(done), (c == 19) ? 1 : 0);
            end else begin
                chk("r3.c21.busy", 32'(busy), 1);
                chk("r3.c21.rd_en", 32'(rd_en), 1);
                chk("r3.c21.rd_a", 32'(rd_addr_a), 0);
                chk("r3.c21.rd_b", 32'(rd_addr_b), 1);
                chk("r3.c21.stage", 32'(stage), 0);
            end
            start = (c == 8) || (c >= 10);
            tick();
        end

        // Run 4 (began at run-3 cycle 21 = cycle 1 here): reset mid-DRAIN.
        start = 1'b0;
        for (int d = 2; d <= 11; d++) begin
            chk($sformatf("r4.c%0d.rd_a", d), 32'(rd_addr_a), 32'(a_t[d]));
            if (d == 11) rst_n = 1'b0;
            tick();
        end
        chk_zero("r4.c12");
        rst_n = 1'b1;
        for (int d = 13; d <= 32; d++) begin
            chk($sformatf("r4.c%0d.wr_en", d), 32'(wr_en), 0);
            chk($sformatf("r4.c%0d.busy", d), 32'(busy), 0);
            tick();
        end

        // 16-point, PIPE=5 instance.
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        for (int c = 1; c <= 54; c++) begin
            if (c == 45) begin
                chk("r6.c45.rd_en", 32'(rd_en6), 1);
                chk("r6.c45.stage", 32'(stage6), 3);
                chk("r6.c45.rd_a", 32'(rd_addr_a6), 5);
                chk("r6.c45.rd_b", 32'(rd_addr_b6), 13);
                chk("r6.c45.tw", 32'(tw_addr6), 5);
            end
            if (c == 50) chk("r6.c50.wr_a", 32'(wr_addr_a6), 5);
            if (c >= 52) chk($sformatf("r6.c%0d.done", c), 32'(done6), (c == 53) ? 1 : 0);
            if (c == 54) begin
                chk("r6.c54.busy", 32'(busy6), 0);
                chk("r6.c54.err", 32'(err6), 0);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
